// File: rtl/aq_djpeg_dht_tables.sv
// JPEG DHT segment parser feeding per-table canonical Huffman decode tables with a 2-cycle lookup port.
// Optional parse-error detection is enabled by defining AQ_DJPEG_DHT_ERR_EN.
module aq_djpeg_dht_tables #(
    parameter int NUM_ID = 2,
    localparam int ID_W = $clog2(NUM_ID)
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            DhtStart,
    input  logic [15:0]     DhtLength,
    input  logic            DhtValid,
    input  logic [7:0]      DhtData,
    output logic            DhtReady,
    output logic            DhtDone,
    input  logic            LookupEnable,
    input  logic            LookupClass,
    input  logic [ID_W-1:0] LookupId,
    input  logic [4:0]      LookupLength,
    input  logic [15:0]     LookupCode,
    output logic            LookupHit,
    output logic [3:0]      ZeroTable,
    output logic [3:0]      WidhtTable,
    output logic            Error
);

    // state   | meaning
    // IDLE    | no segment active, not accepting bytes
    // HDR     | waiting for Tc/Th byte of next table
    // COUNTS  | collecting the 16 code-length counts
    // CODEGEN | 16 cycles building mincode/maxcode/valptr per length
    // SYMS    | writing Total symbol bytes into the table's RAM

    localparam int TW    = ID_W + 1;
    localparam int NUM_T = 2 * NUM_ID;
    localparam int LN_N  = NUM_T * 16;
    localparam int SYM_N = NUM_T * 256;

    typedef enum logic [2:0] {IDLE, HDR, COUNTS, CODEGEN, SYMS} state_t;

    state_t            state, stateNext;
    logic [15:0]       remaining, remAfter;
    logic [8:0]        total, totalNext;
    logic [9:0]        sumWide;
    logic [3:0]        idx;
    logic [7:0]        symIdx;
    logic [16:0]       code, codeSum;
    logic [7:0]        ptr;
    logic [TW-1:0]     curT, hdrT;
    logic [NUM_T-1:0]  valid;
    logic [7:0]        cntCur;
    logic              accept, symLast, finish, errSet, doneNext;
    logic              hdrBad, totalBad, remBad;

    logic [7:0]        cntW    [16];
    logic [7:0]        mincode [LN_N];
    logic [16:0]       maxcode [LN_N];
    logic [7:0]        valptr  [LN_N];
    logic              nz      [LN_N];
    logic [7:0]        symRam  [SYM_N];

    assign DhtReady = (state == HDR) || (state == COUNTS) || (state == SYMS);
    assign accept   = DhtValid && DhtReady;
    assign hdrT     = {DhtData[4], DhtData[ID_W-1:0]};
    assign sumWide  = {1'b0, total} + {2'b00, DhtData};
    assign remAfter = (accept && remaining != 16'd0) ? remaining - 16'd1 : remaining;
    assign symLast  = ({1'b0, symIdx} == total - 9'd1);
    assign cntCur   = cntW[idx];
    assign codeSum  = code + {9'd0, cntCur};

`ifdef AQ_DJPEG_DHT_ERR_EN
    // Saturate so a pathological count sum cannot wrap back under the 256 limit.
    assign totalNext = sumWide[9] ? 9'h1FF : sumWide[8:0];
    assign hdrBad    = (DhtData[7:5] != 3'd0) || (32'(DhtData[3:0]) >= NUM_ID);
    assign totalBad  = (sumWide > 10'd256) || (!curT[TW-1] && sumWide > 10'd16);
    assign remBad    = (remaining <= 16'd1);
`else
    logic unusedBits;
    assign unusedBits = ^{DhtData[7:5], DhtData[3:ID_W], sumWide[9:8]};
    assign totalNext  = {1'b0, sumWide[7:0]};
    assign hdrBad     = 1'b0;
    assign totalBad   = 1'b0;
    assign remBad     = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        doneNext  = 1'b0;
        errSet    = 1'b0;
        finish    = 1'b0;
        if (DhtStart) begin
            stateNext = (DhtLength == 16'd0) ? IDLE : HDR;
            doneNext  = (DhtLength == 16'd0);
        end else begin
            unique case (state)
                IDLE: stateNext = IDLE;
                HDR: if (accept) begin
                    if (hdrBad || remBad) errSet = 1'b1;
                    else stateNext = COUNTS;
                end
                COUNTS: if (accept) begin
                    if (idx == 4'd15) begin
                        if (totalBad || (remBad && totalNext != 9'd0)) errSet = 1'b1;
                        else stateNext = CODEGEN;
                    end else if (remBad) begin
                        errSet = 1'b1;
                    end
                end
                CODEGEN: if (idx == 4'd15) begin
                    if (total == 9'd0) finish = 1'b1;
                    else stateNext = SYMS;
                end
                SYMS: if (accept) begin
                    if (symLast) finish = 1'b1;
                    else if (remBad) errSet = 1'b1;
                end
                default: stateNext = IDLE;
            endcase
            if (finish) begin
                stateNext = (remAfter == 16'd0) ? IDLE : HDR;
                doneNext  = (remAfter == 16'd0);
            end
            if (errSet) stateNext = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 16'd0;
            total     <= 9'd0;
            idx       <= 4'd0;
            symIdx    <= 8'd0;
            code      <= 17'd0;
            ptr       <= 8'd0;
            curT      <= '0;
            valid     <= '0;
            DhtDone   <= 1'b0;
        end else begin
            state     <= stateNext;
            DhtDone   <= doneNext;
            remaining <= remAfter;
            if (DhtStart) begin
                remaining <= DhtLength;
                total     <= 9'd0;
                idx       <= 4'd0;
            end else begin
                unique case (state)
                    HDR: if (accept) begin
                        curT        <= hdrT;
                        valid[hdrT] <= 1'b0;
                        total       <= 9'd0;
                        idx         <= 4'd0;
                        code        <= 17'd0;
                        ptr         <= 8'd0;
                    end
                    COUNTS: if (accept) begin
                        total <= totalNext;
                        idx   <= idx + 4'd1;
                    end
                    CODEGEN: begin
                        idx    <= idx + 4'd1;
                        code   <= {codeSum[15:0], 1'b0};
                        ptr    <= ptr + cntCur;
                        symIdx <= 8'd0;
                    end
                    SYMS: if (accept) symIdx <= symIdx + 8'd1;
                    default: ;
                endcase
                if (finish) valid[curT] <= 1'b1;
            end
        end
    end

`ifdef AQ_DJPEG_DHT_ERR_EN
    logic errReg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) errReg <= 1'b0;
        else if (errSet) errReg <= 1'b1;
    end
    assign Error = errReg;
`else
    assign Error = 1'b0;
`endif

    // Table storage has no reset; the Valid flags gate every use.
    always_ff @(posedge clk) begin
        if (state == COUNTS && accept && !DhtStart) cntW[idx] <= DhtData;
        if (state == CODEGEN) begin
            mincode[{curT, idx}] <= code[7:0];
            maxcode[{curT, idx}] <= codeSum - 17'd1;
            valptr[{curT, idx}]  <= ptr;
            nz[{curT, idx}]      <= (cntCur != 8'd0);
        end
        if (state == SYMS && accept && !DhtStart) symRam[{curT, symIdx}] <= DhtData;
    end

    logic [TW-1:0]   lkT, rdT;
    logic [3:0]      lkIdx;
    logic [TW+3:0]   lkSel;
    logic            lkLenOk, lkHit, rdEn;
    logic [7:0]      lkAddr, rdAddr, symOut;

    assign lkT     = {LookupClass, LookupId};
    assign lkIdx   = LookupLength[3:0] - 4'd1;
    assign lkSel   = {lkT, lkIdx};
    assign lkLenOk = (LookupLength != 5'd0) && (LookupLength <= 5'd16);
    assign lkHit   = lkLenOk && valid[lkT] && nz[lkSel] && ({1'b0, LookupCode} <= maxcode[lkSel]);
    assign lkAddr  = valptr[lkSel] + LookupCode[7:0] - mincode[lkSel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LookupHit <= 1'b0;
            rdAddr    <= 8'd0;
            rdT       <= '0;
            rdEn      <= 1'b0;
            symOut    <= 8'd0;
        end else begin
            rdEn <= LookupEnable;
            if (LookupEnable) begin
                LookupHit <= lkHit;
                rdAddr    <= lkAddr;
                rdT       <= lkT;
            end
            if (rdEn) symOut <= symRam[{rdT, rdAddr}];
        end
    end

    assign ZeroTable  = symOut[7:4];
    assign WidhtTable = symOut[3:0];

endmodule
